edge_timestamp_fifo: RTL

Timestamps rising edges of a single-bit result signal, such as the output of the two-input AND stage, against a free-running cycle counter. Each timestamp is queued in a small FIFO and presented downstream over a valid/ready interface. Sits directly downstream of the combinational gate stage and turns its level output into time-tagged events for logging and checking logic. Overflow is detected, counted and flagged, never silent.

---
 rtl/edge_timestamp_fifo_pkg.sv | 10 +
 rtl/edge_timestamp_fifo_if.sv | 26 ++
 rtl/sync_fifo.sv | 91 +++++++++
 rtl/edge_timestamp_fifo.sv | 91 +++++++++
 4 files changed

// File: rtl/edge_timestamp_fifo_pkg.sv
// Shared defaults and types for the edge timestamp FIFO block.
package edge_ts_pkg;

  localparam int TS_W_DEF   = 32;  // cycle-counter / timestamp width
  localparam int DEPTH_DEF  = 4;   // FIFO entries, power of two
  localparam int DROP_W_DEF = 8;   // dropped-event counter width

  typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/edge_timestamp_fifo_if.sv
// Valid/ready stream carrying one timestamp per transfer.
interface edge_timestamp_fifo_if
  import edge_ts_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);

  logic            ts_valid;
  logic            ts_ready;
  logic [TS_W-1:0] ts_data;

  // Producer side: the timestamp FIFO.
  modport master (
    output ts_valid,
    output ts_data,
    input  ts_ready
  );

  // Consumer side: logging / checking logic.
  modport slave (
    input  ts_valid,
    input  ts_data,
    output ts_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head entry. Read/write pointers
// carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO is only taken when a pop happens in the same
// cycle; a pop from an empty FIFO is ignored.
module sync_fifo
  import edge_ts_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [PW-1:0]    used;
  logic [AW-1:0]    rd_next_idx;
  logic             push_ok;
  logic             pop_ok;

  assign used        = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level       = LVL_W'(used);
  assign head        = head_q;
  assign pop_ok      = pop & ~empty;
  assign push_ok     = push & (~full | pop_ok);
  assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);

  // Next pointers and next head entry; clr empties the FIFO outright.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      head_d   = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      // New data becomes head when it lands in an empty (or emptying) FIFO;
      // otherwise a pop advances the head to the next stored entry.
      if (push_ok && (empty || (pop_ok && used == PW'(1)))) begin
        head_d = wdata;
      end else if (pop_ok && used != PW'(1)) begin
        head_d = mem_q[rd_next_idx];
      end
    end
  end

  // Pointer and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; written at the write pointer on every accepted push.
  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/edge_timestamp_fifo.sv
// Rising-edge timestamper: registers the monitored signal, detects rising
// edges, tags each with a free-running cycle count and queues the tag for a
// valid/ready consumer. Events that find the queue full are dropped, counted
// (saturating) and flagged by a sticky overflow bit.
module edge_timestamp_fifo
  import edge_ts_pkg::*;
#(
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sig,
  input  logic                       clr,
  edge_timestamp_fifo_if.master      ts_if,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic              sig_q, sig_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              rise;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  // A signal already high at the first edge after reset or clr counts as a
  // rise because sig_q starts from 0.
  assign rise = sig & ~sig_q;
  assign pop  = ts_if.ts_valid & ts_if.ts_ready;
  // A full FIFO still takes the event if the head leaves in the same cycle.
  assign drop = rise & fifo_full & ~pop;

  assign ts_if.ts_valid = ~fifo_empty;
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (rise),
    .wdata (ts_cnt_q),
    .pop   (pop),
    .head  (ts_if.ts_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Cycle counter, edge history and overflow bookkeeping; clr wins over all.
  always_comb begin
    ts_cnt_d   = ts_cnt_q + TS_W'(1);
    sig_d      = sig;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      ts_cnt_d   = '0;
      sig_d      = 1'b0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // State registers for the counter, edge detector and drop tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q   <= '0;
      sig_q      <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      sig_q      <= sig_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
